// File: rtl/cnn_pkg.sv
// Shared widths and datapath helpers for the CNN post-convolution stages.
package cnn_pkg;

  localparam int IN_W        = 14;
  localparam int OUT_W       = 12;
  localparam int CONV2_IMG_W = 8;
  localparam int POOL2_OUT_W = CONV2_IMG_W / 2;

  function automatic logic [IN_W-2:0] relu(input logic signed [IN_W-1:0] x);
    return x[IN_W-1] ? '0 : x[IN_W-2:0];
  endfunction

  // Clamp a non-negative activation to the largest OUT_W-bit code.
  function automatic logic [OUT_W-1:0] sat(input logic [IN_W-2:0] p);
    return (|p[IN_W-2:OUT_W]) ? '1 : p[OUT_W-1:0];
  endfunction

endpackage

// File: rtl/pool2x2_lane.sv
// One channel of ReLU + 2x2 max pooling + saturation, sequenced by the
// shared column/row counters of the parent block.
module pool2x2_lane
  import cnn_pkg::*;
#(
  parameter int IMG_W = CONV2_IMG_W,
  localparam int HALF = IMG_W / 2,
  localparam int HW   = (HALF > 1) ? $clog2(HALF) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   accept_i,
  input  logic                   col_odd_i,
  input  logic                   row_odd_i,
  input  logic [HW-1:0]          half_col_i,
  input  logic signed [IN_W-1:0] conv_i,
  output logic [OUT_W-1:0]       pool_o
);

  logic [IN_W-2:0]  relu_w;
  logic [IN_W-2:0]  h_w;
  logic [IN_W-2:0]  p_w;
  logic [IN_W-2:0]  pair_q;
  logic [IN_W-2:0]  linebuf_q [HALF];
  logic [OUT_W-1:0] pool_q;

  always_comb begin
    relu_w = relu(conv_i);
    h_w    = (relu_w > pair_q) ? relu_w : pair_q;
    p_w    = (linebuf_q[half_col_i] > h_w) ? linebuf_q[half_col_i] : h_w;
  end

  // Even rows park the horizontal max; odd rows finish the 2x2 window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pair_q <= '0;
      for (int i = 0; i < HALF; i++) linebuf_q[i] <= '0;
      pool_q <= '0;
    end else if (accept_i) begin
      if (!col_odd_i)      pair_q                <= relu_w;
      else if (!row_odd_i) linebuf_q[half_col_i] <= h_w;
      else                 pool_q                <= sat(p_w);
    end
  end

  assign pool_o = pool_q;

endmodule

// File: rtl/conv2_relu_maxpool.sv
// ReLU + 2x2/2 max pool + saturation for the three conv2 output channels,
// streaming in raster order with shared position counters.
module conv2_relu_maxpool
  import cnn_pkg::*;
#(
  parameter int IMG_W = CONV2_IMG_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   valid_in,
  input  logic signed [IN_W-1:0] conv_in_1,
  input  logic signed [IN_W-1:0] conv_in_2,
  input  logic signed [IN_W-1:0] conv_in_3,
  output logic [OUT_W-1:0]       pool_out_1,
  output logic [OUT_W-1:0]       pool_out_2,
  output logic [OUT_W-1:0]       pool_out_3,
  output logic                   valid_out,
  output logic                   frame_done
);

  localparam int CW   = $clog2(IMG_W);
  localparam int HALF = IMG_W / 2;
  localparam int HW   = (HALF > 1) ? $clog2(HALF) : 1;

  logic [CW-1:0] col_q, col_d;
  logic [CW-1:0] row_q, row_d;
  logic          last_col_w, last_row_w;
  logic [HW-1:0] half_col_w;
  logic          valid_out_q, frame_done_q;

  always_comb begin
    last_col_w = (col_q == CW'(IMG_W - 1));
    last_row_w = (row_q == CW'(IMG_W - 1));
    col_d      = last_col_w ? '0 : col_q + 1'b1;
    row_d      = row_q;
    if (last_col_w) row_d = last_row_w ? '0 : row_q + 1'b1;
    half_col_w = HW'(col_q >> 1);
  end

  // Output strobes are registered alongside the lane outputs so they align.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q        <= '0;
      row_q        <= '0;
      valid_out_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      valid_out_q  <= valid_in & col_q[0] & row_q[0];
      frame_done_q <= valid_in & last_col_w & last_row_w;
      if (valid_in) begin
        col_q <= col_d;
        row_q <= row_d;
      end
    end
  end

  pool2x2_lane #(.IMG_W(IMG_W)) u_lane_1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .accept_i   (valid_in),
    .col_odd_i  (col_q[0]),
    .row_odd_i  (row_q[0]),
    .half_col_i (half_col_w),
    .conv_i     (conv_in_1),
    .pool_o     (pool_out_1)
  );

  pool2x2_lane #(.IMG_W(IMG_W)) u_lane_2 (
    .clk        (clk),
    .rst_n      (rst_n),
    .accept_i   (valid_in),
    .col_odd_i  (col_q[0]),
    .row_odd_i  (row_q[0]),
    .half_col_i (half_col_w),
    .conv_i     (conv_in_2),
    .pool_o     (pool_out_2)
  );

  pool2x2_lane #(.IMG_W(IMG_W)) u_lane_3 (
    .clk        (clk),
    .rst_n      (rst_n),
    .accept_i   (valid_in),
    .col_odd_i  (col_q[0]),
    .row_odd_i  (row_q[0]),
    .half_col_i (half_col_w),
    .conv_i     (conv_in_3),
    .pool_o     (pool_out_3)
  );

  assign valid_out  = valid_out_q;
  assign frame_done = frame_done_q;

endmodule
